dram_uart_dumper: RTL and testbench

- Downstream consumer of the control unit's start_Tx strobe. When the control unit reaches its end state, this block streams the processed image out of data RAM over a UART line.
- It reads NUM_BYTES consecutive DRAM words from START_ADDR and serialises each one as 8N1, LSB first.
- It drives the DRAM read port while active. The top level muxes dram_addr over the MAR path whenever dram_rd_active=1.

---
 rtl/dram_uart_dumper_pkg.sv | 25 ++
 rtl/dram_uart_dumper_uart_tx_serializer.sv | 99 +++++++++
 rtl/dram_uart_dumper.sv | 133 +++++++++++++
 tb/tb_dram_uart_dumper.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/dram_uart_dumper_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dram_uart_dumper_pkg
// Description : Shared state encoding and 8N1 frame constants for the dumper.
// Revision    : 1.0 - initial release
// ============================================================================
package dram_uart_dumper_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        LOAD  = 3'd2,
        START = 3'd3,
        DATA  = 3'd4,
        STOP  = 3'd5,
        DONE  = 3'd6
    } state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam int   FRAME_BITS = 10;
    localparam int   DATA_BITS  = FRAME_BITS - 2;

endpackage : dram_uart_dumper_pkg
`default_nettype wire

// File: rtl/dram_uart_dumper_uart_tx_serializer.sv
`default_nettype none
// ============================================================================
// Module      : dram_uart_dumper_uart_tx_serializer
// Description : 8N1 LSB-first UART transmitter with load/ready handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_uart_dumper_uart_tx_serializer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DATA_WIDTH   = 8
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  load,
    input  logic [DATA_WIDTH-1:0] load_data,
    output logic                  ready,
    output logic                  frame_done,
    output logic                  tx
);
    import dram_uart_dumper_pkg::*;

    localparam int c_baud_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int c_bit_w  = $clog2(DATA_BITS);
    localparam logic [c_baud_w-1:0] c_baud_last = c_baud_w'(CLKS_PER_BIT - 1);
    localparam logic [c_bit_w-1:0]  c_bit_last  = c_bit_w'(DATA_BITS - 1);

    state_t                r_state;
    logic [c_baud_w-1:0]   r_baud_cnt;
    logic [c_bit_w-1:0]    r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_tx;
    logic                  w_bit_end;

    assign w_bit_end  = (r_baud_cnt == c_baud_last);
    assign ready      = (r_state == IDLE);
    // Combinational so the dumper can issue the next READ on the very edge
    // that ends the stop bit, keeping the inter-frame gap at two cycles.
    assign frame_done = (r_state == STOP) && w_bit_end;
    assign tx         = r_tx;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= IDLE;
            r_baud_cnt <= '0;
            r_bit_cnt  <= '0;
            r_shift    <= '0;
            r_tx       <= STOP_BIT;
        end else begin
            case (r_state)
                IDLE: begin
                    if (load) begin
                        r_shift    <= load_data;
                        r_baud_cnt <= '0;
                        r_tx       <= START_BIT;
                        r_state    <= START;
                    end
                end
                START: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_bit_cnt  <= '0;
                        r_tx       <= r_shift[0];
                        r_state    <= DATA;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_shift    <= {1'b0, r_shift[DATA_WIDTH-1:1]};
                        r_bit_cnt  <= r_bit_cnt + 1'b1;
                        if (r_bit_cnt == c_bit_last) begin
                            r_tx    <= STOP_BIT;
                            r_state <= STOP;
                        end else begin
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (w_bit_end) begin
                        r_baud_cnt <= '0;
                        r_state    <= IDLE;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                default: begin
                    r_tx    <= STOP_BIT;
                    r_state <= IDLE;
                end
            endcase
        end
    end

endmodule : dram_uart_dumper_uart_tx_serializer
`default_nettype wire

// File: rtl/dram_uart_dumper.sv
`default_nettype none
// ============================================================================
// Module      : dram_uart_dumper
// Description : Streams NUM_BYTES DRAM words from START_ADDR out as 8N1 UART.
// Revision    : 1.0 - initial release
// ============================================================================
module dram_uart_dumper #(
    parameter int CLKS_PER_BIT = 434,
    parameter int ADDR_WIDTH   = 16,
    parameter int DATA_WIDTH   = 8,
    parameter int START_ADDR   = 0,
    parameter int NUM_BYTES    = 16384
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start_Tx,
    input  logic [DATA_WIDTH-1:0] dram_rdata,
    output logic [ADDR_WIDTH-1:0] dram_addr,
    output logic                  dram_rd_active,
    output logic                  tx,
    output logic                  busy,
    output logic                  done
);
    import dram_uart_dumper_pkg::*;

    localparam int c_cnt_w = $clog2(NUM_BYTES + 1);
    localparam logic [c_cnt_w-1:0]    c_last_byte  = c_cnt_w'(NUM_BYTES - 1);
    localparam logic [ADDR_WIDTH-1:0] c_start_addr = ADDR_WIDTH'(START_ADDR);

    state_t                r_state;
    logic                  r_start_q;
    logic                  r_armed;
    logic [c_cnt_w-1:0]    r_byte_cnt;
    logic [ADDR_WIDTH-1:0] r_dram_addr;
    logic                  r_rd_active;
    logic                  r_busy;
    logic                  r_done;
    logic                  w_start_edge;
    logic                  w_ser_load;
    logic                  w_ser_ready;
    logic                  w_frame_done;

    // A level already high when reset releases is not a fresh request:
    // the line must be seen low at least once before an edge can arm a dump.
    assign w_start_edge = start_Tx && !r_start_q && r_armed;
    assign w_ser_load   = (r_state == LOAD) && w_ser_ready;

    assign dram_addr      = r_dram_addr;
    assign dram_rd_active = r_rd_active;
    assign busy           = r_busy;
    assign done           = r_done;

    dram_uart_dumper_uart_tx_serializer #(
        .CLKS_PER_BIT (CLKS_PER_BIT),
        .DATA_WIDTH   (DATA_WIDTH)
    ) u_serializer (
        .clock      (clock),
        .reset_n    (reset_n),
        .load       (w_ser_load),
        .load_data  (dram_rdata),
        .ready      (w_ser_ready),
        .frame_done (w_frame_done),
        .tx         (tx)
    );

    // START here covers the whole frame in flight; the serializer refines it
    // into its own START/DATA/STOP phases.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_start_q   <= 1'b0;
            r_armed     <= 1'b0;
            r_byte_cnt  <= '0;
            r_dram_addr <= c_start_addr;
            r_rd_active <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_start_q <= start_Tx;
            if (!start_Tx) begin
                r_armed <= 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_start_edge) begin
                        r_busy      <= 1'b1;
                        r_rd_active <= 1'b1;
                        r_dram_addr <= c_start_addr;
                        r_byte_cnt  <= '0;
                        r_state     <= READ;
                    end
                end
                READ: begin
                    r_state <= LOAD;
                end
                LOAD: begin
                    if (w_ser_ready) begin
                        r_state <= START;
                    end
                end
                START: begin
                    if (w_frame_done) begin
                        if (r_byte_cnt == c_last_byte) begin
                            r_busy      <= 1'b0;
                            r_rd_active <= 1'b0;
                            r_done      <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_byte_cnt  <= r_byte_cnt + 1'b1;
                            r_dram_addr <= r_dram_addr + 1'b1;
                            r_state     <= READ;
                        end
                    end
                end
                DONE: begin
                    if (!start_Tx) begin
                        r_done  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_busy      <= 1'b0;
                    r_rd_active <= 1'b0;
                    r_done      <= 1'b0;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

endmodule : dram_uart_dumper
`default_nettype wire

// File: tb/tb_dram_uart_dumper.sv
`default_nettype none
// ============================================================================
// Module      : tb_dram_uart_dumper
// Description : Self-checking bench: waveform-level model of the UART dump.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dram_uart_dumper;

    localparam int CPB   = 4;
    localparam int NB    = 3;
    localparam int SA    = 16'h0010;
    localparam int FRAME = 10 * CPB + 2;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start_Tx;
    logic        start1;
    logic [7:0]  rdata0, rdata1;
    logic [15:0] addr0, addr1;
    logic        rd0, rd1, tx0, tx1, busy0, busy1, done0, done1;
    logic [7:0]  mem [0:65535];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clock = ~clock;

    always @(posedge clock) begin
        rdata0 <= mem[addr0];
        rdata1 <= mem[addr1];
    end

    dram_uart_dumper #(
        .CLKS_PER_BIT (CPB), .ADDR_WIDTH (16), .DATA_WIDTH (8),
        .START_ADDR   (SA),  .NUM_BYTES  (NB)
    ) u_dut (
        .clock (clock), .reset_n (reset_n), .start_Tx (start_Tx),
        .dram_rdata (rdata0), .dram_addr (addr0), .dram_rd_active (rd0),
        .tx (tx0), .busy (busy0), .done (done0)
    );

    dram_uart_dumper #(
        .CLKS_PER_BIT (CPB), .ADDR_WIDTH (16), .DATA_WIDTH (8),
        .START_ADDR   (SA),  .NUM_BYTES  (1)
    ) u_dut1 (
        .clock (clock), .reset_n (reset_n), .start_Tx (start1),
        .dram_rdata (rdata1), .dram_addr (addr1), .dram_rd_active (rd1),
        .tx (tx1), .busy (busy1), .done (done1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    // Raise start_Tx, record the line for a fixed window and compare it with
    // the frame sequence the DRAM contents imply. drop_at<0 keeps start high.
    task automatic run_dump(input string tag, input int drop_at);
        int          len = NB * FRAME + 30;
        logic        tx_s[$];
        logic        exp_tx[$];
        logic [7:0]  exp_b[$];
        logic [7:0]  got_b[$];
        logic [15:0] addrs[$];
        int          busy_n = 0, done_n = 0, wave_err = 0;
        int          start_bad = 0, stop_bad = 0, i = 0;
        logic        last_done = 1'b0;
        logic [7:0]  byte_v;

        for (int b = 0; b < NB; b++) exp_b.push_back(mem[SA + b]);
        foreach (exp_b[b]) begin
            exp_tx.push_back(1'b1);
            exp_tx.push_back(1'b1);
            repeat (CPB) exp_tx.push_back(1'b0);
            for (int k = 0; k < 8; k++) repeat (CPB) exp_tx.push_back(exp_b[b][k]);
            repeat (CPB) exp_tx.push_back(1'b1);
        end
        while (exp_tx.size() < len) exp_tx.push_back(1'b1);

        @(negedge clock);
        start_Tx = 1'b1;
        for (int k = 0; k < len; k++) begin
            @(negedge clock);
            tx_s.push_back(tx0);
            if (busy0) busy_n++;
            if (done0) done_n++;
            last_done = done0;
            if (rd0 && (addrs.size() == 0 || addrs[$] != addr0)) addrs.push_back(addr0);
            if (k == drop_at) start_Tx = 1'b0;
        end

        for (int k = 0; k < len; k++) if (tx_s[k] !== exp_tx[k]) wave_err++;
        check($sformatf("%s waveform_errs", tag), wave_err, 0);

        while (i + 10 * CPB <= len) begin
            if (tx_s[i] === 1'b0) begin
                for (int j = 0; j < CPB; j++) if (tx_s[i + j] !== 1'b0) start_bad++;
                for (int k = 0; k < 8; k++) byte_v[k] = tx_s[i + CPB * (k + 1) + CPB / 2];
                if (tx_s[i + 9 * CPB + CPB / 2] !== 1'b1) stop_bad++;
                got_b.push_back(byte_v);
                i += 10 * CPB;
            end else begin
                i++;
            end
        end
        check($sformatf("%s frames", tag), got_b.size(), NB);
        for (int b = 0; b < NB; b++)
            check($sformatf("%s byte%0d", tag, b),
                  (b < got_b.size()) ? {24'd0, got_b[b]} : 32'hDEAD, {24'd0, exp_b[b]});
        check($sformatf("%s start_bit_len", tag), start_bad, 0);
        check($sformatf("%s stop_bit", tag), stop_bad, 0);
        check($sformatf("%s busy_cycles", tag), busy_n, NB * FRAME);
        check($sformatf("%s addr_count", tag), addrs.size(), NB);
        for (int b = 0; b < NB && b < addrs.size(); b++)
            check($sformatf("%s addr%0d", tag, b), addrs[b], SA + b);
        if (drop_at >= 0) begin
            check($sformatf("%s done_pulse", tag), done_n, 1);
            check($sformatf("%s done_end", tag), last_done, 1'b0);
        end else begin
            check($sformatf("%s done_end", tag), last_done, 1'b1);
            check($sformatf("%s rd_active_end", tag), rd0, 1'b0);
        end
    endtask

    initial begin
        int   bad;
        int   first_low, low_run, high_run, busy1_n;
        logic tx1_s[$];
        logic done1_at;

        reset_n  = 1'b0;
        start_Tx = 1'b0;
        start1   = 1'b0;
        for (int a = 0; a < 65536; a++) mem[a] = 8'h00;
        mem[SA]     = 8'hA5;
        mem[SA + 1] = 8'h3C;
        mem[SA + 2] = 8'hFF;

        repeat (5) @(negedge clock);
        check("rst tx", tx0, 1'b1);
        check("rst busy", busy0, 1'b0);
        check("rst done", done0, 1'b0);
        check("rst rd_active", rd0, 1'b0);
        check("rst addr", addr0, SA);

        reset_n = 1'b1;
        bad = 0;
        repeat (50) begin
            @(negedge clock);
            if (tx0 !== 1'b1 || busy0 !== 1'b0 || done0 !== 1'b0 || rd0 !== 1'b0) bad++;
        end
        check("idle_50 bad_cycles", bad, 0);

        run_dump("dump1", -1);
        @(negedge clock);
        start_Tx = 1'b0;
        @(negedge clock);
        check("done_clear", done0, 1'b0);
        check("idle_busy", busy0, 1'b0);

        run_dump("dump2", -1);
        @(negedge clock);
        start_Tx = 1'b0;
        @(negedge clock);

        run_dump("drop_b2", FRAME + 10);
        @(negedge clock);

        for (int it = 0; it < 4; it++) begin
            for (int b = 0; b < NB; b++) mem[SA + b] = 8'($urandom);
            run_dump($sformatf("rand%0d", it),
                     ($urandom_range(0, 1) == 1) ? int'($urandom_range(0, NB * FRAME - 1)) : -1);
            @(negedge clock);
            start_Tx = 1'b0;
            repeat ($urandom_range(1, 4)) @(negedge clock);
        end

        // Reset on the 7th cycle of byte 1's DATA phase (bit 1 of 0xA5 is 0).
        mem[SA] = 8'hA5;
        @(negedge clock);
        start_Tx = 1'b1;
        repeat (13) @(negedge clock);
        check("pre_reset tx", tx0, 1'b0);
        reset_n = 1'b0;
        #1;
        check("mid_reset tx", tx0, 1'b1);
        check("mid_reset busy", busy0, 1'b0);
        check("mid_reset rd_active", rd0, 1'b0);
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        bad = 0;
        repeat (100) begin
            @(negedge clock);
            if (busy0 !== 1'b0 || tx0 !== 1'b1) bad++;
        end
        check("no_retrigger bad_cycles", bad, 0);
        start_Tx = 1'b0;
        repeat (2) @(negedge clock);
        run_dump("after_reset", -1);
        @(negedge clock);
        start_Tx = 1'b0;
        repeat (2) @(negedge clock);

        // Single-byte variant: one all-zero frame.
        mem[SA] = 8'h00;
        start1 = 1'b1;
        busy1_n = 0;
        done1_at = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clock);
            tx1_s.push_back(tx1);
            if (busy1) busy1_n++;
            if (k == FRAME) done1_at = done1;
        end
        first_low = -1;
        for (int k = 0; k < 60 && first_low < 0; k++) if (tx1_s[k] === 1'b0) first_low = k;
        low_run = 0;
        high_run = 0;
        if (first_low >= 0) begin
            for (int k = first_low; k < 60 && tx1_s[k] === 1'b0; k++) low_run++;
            for (int k = first_low + low_run; k < 60 && tx1_s[k] === 1'b1; k++) high_run++;
        end
        check("nb1 first_low", first_low, 2);
        check("nb1 low_cycles", low_run, 9 * CPB);
        check("nb1 trailing_high", high_run, 60 - 2 - 9 * CPB);
        check("nb1 busy_cycles", busy1_n, FRAME);
        check("nb1 done", done1_at, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule : tb_dram_uart_dumper
`default_nettype wire
